// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared types and sizes for the lu matrix buffer
// Ports: none (package).
package lu_pkg;

    localparam int WIDTH = 64;
    localparam int SIZE  = 32;

    // One complex element: real part in the low WIDTH bits, imaginary in the high.
    typedef struct packed {
        logic [WIDTH-1:0] im;
        logic [WIDTH-1:0] re;
    } cplx_t;

    // Element j of a row sits at bits [j*2*WIDTH +: 2*WIDTH].
    typedef cplx_t [SIZE-1:0] row_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DUMP
    } lu_buf_state_e;

endpackage

// File: rtl/lu_row_ram.sv
// rtl/lu_row_ram.sv - row storage with registered read-before-write port
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset of the read pipeline
//   rd_en, rd_addr                  synchronous read request
//   rd_data, rd_addr_q, rd_valid    registered read result, address echo and valid
//   wr_en, wr_addr, wr_data         write port, updates storage on the clock edge
//   peek_addr, peek_data            combinational view used to stream the dump
module lu_row_ram #(
    parameter int SIZE  = 32,
    parameter int ROW_W = 4096,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ROW_W-1:0] rd_data,
    output logic [AW-1:0]    rd_addr_q,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic [AW-1:0]    peek_addr,
    output logic [ROW_W-1:0] peek_data
);

    logic [ROW_W-1:0] mem [SIZE];

    // Storage contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sampling mem on the same edge as the write yields the old row on a
    // same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data   <= '0;
            rd_addr_q <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data   <= mem[rd_addr];
                rd_addr_q <= rd_addr;
            end
        end
    end

    assign peek_data = mem[peek_addr];

endmodule

// File: rtl/lu_mat_buf.sv
// rtl/lu_mat_buf.sv - complex matrix buffer feeding and collecting rows for the lu engine
// Ports:
//   clk_i, rst_ni, flush_i                               clock, async active-low reset, sync abort
//   load_row_i, load_valid_i, load_ready_o               host row input stream
//   lu_start_o, lu_busy_i                                lu start pulse and busy status
//   lu_rd_addr_i, lu_rd_valid_i                          lu row read request
//   lu_row_o, lu_row_addr_o, lu_row_valid_o              read result, one cycle after request
//   lu_wr_row_i, lu_wr_addr_i, lu_wr_valid_i, lu_wr_ready_o  lu row write-back
//   dump_row_o, dump_addr_o, dump_valid_o, dump_ready_i  result row stream to host
//   busy_o                                               high whenever not idle
module lu_mat_buf #(
    parameter int SIZE   = lu_pkg::SIZE,
    parameter int WIDTH  = lu_pkg::WIDTH,
    localparam int AW    = $clog2(SIZE),
    localparam int ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [ROW_W-1:0] load_row_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             lu_start_o,
    input  logic             lu_busy_i,
    input  logic [AW-1:0]    lu_rd_addr_i,
    input  logic             lu_rd_valid_i,
    output logic [ROW_W-1:0] lu_row_o,
    output logic [AW-1:0]    lu_row_addr_o,
    output logic             lu_row_valid_o,
    input  logic [ROW_W-1:0] lu_wr_row_i,
    input  logic [AW-1:0]    lu_wr_addr_i,
    input  logic             lu_wr_valid_i,
    output logic             lu_wr_ready_o,
    output logic [ROW_W-1:0] dump_row_o,
    output logic [AW-1:0]    dump_addr_o,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic             busy_o
);

    lu_pkg::lu_buf_state_e state, state_nx;
    logic [AW-1:0]    cnt, cnt_nx;
    logic             seen_busy, seen_busy_nx;
    logic             last_row;
    logic             load_ready, wr_ready, dump_valid, start;
    logic             load_fire, wb_fire;
    logic             mem_wr_en, mem_rd_en;
    logic [AW-1:0]    mem_wr_addr;
    logic [ROW_W-1:0] mem_wr_data;
    logic [ROW_W-1:0] peek_data;

    assign last_row  = (cnt == AW'(SIZE - 1));
    assign load_fire = load_ready && load_valid_i;
    assign wb_fire   = wr_ready && lu_wr_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= lu_pkg::ST_IDLE;
            cnt       <= '0;
            seen_busy <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            seen_busy <= seen_busy_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        seen_busy_nx = seen_busy;
        load_ready   = 1'b0;
        wr_ready     = 1'b0;
        dump_valid   = 1'b0;
        start        = 1'b0;
        case (state)
            lu_pkg::ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid_i) begin
                    cnt_nx   = AW'(1);
                    state_nx = lu_pkg::ST_LOAD;
                end
            end
            lu_pkg::ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid_i) begin
                    if (last_row) begin
                        cnt_nx   = '0;
                        state_nx = lu_pkg::ST_START;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            lu_pkg::ST_START: begin
                start        = 1'b1;
                seen_busy_nx = 1'b0;
                state_nx     = lu_pkg::ST_RUN;
            end
            lu_pkg::ST_RUN: begin
                wr_ready = 1'b1;
                if (lu_busy_i) begin
                    seen_busy_nx = 1'b1;
                end
                // lu is done only once it has been seen busy and has drained its writes.
                if (!lu_busy_i && seen_busy && !lu_wr_valid_i) begin
                    cnt_nx   = '0;
                    state_nx = lu_pkg::ST_DUMP;
                end
            end
            lu_pkg::ST_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready_i) begin
                    if (last_row) begin
                        cnt_nx   = '0;
                        state_nx = lu_pkg::ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = lu_pkg::ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
        // Abort wins over any handshake in the same cycle: withdraw ready/valid
        // so no transfer is seen on either side.
        if (flush_i) begin
            state_nx     = lu_pkg::ST_IDLE;
            cnt_nx       = '0;
            seen_busy_nx = 1'b0;
            load_ready   = 1'b0;
            wr_ready     = 1'b0;
            dump_valid   = 1'b0;
        end
    end

    // Host loads use the row counter as address; lu write-backs only happen in RUN.
    assign mem_wr_en   = load_fire || wb_fire;
    assign mem_wr_addr = (state == lu_pkg::ST_RUN) ? lu_wr_addr_i : cnt;
    assign mem_wr_data = (state == lu_pkg::ST_RUN) ? lu_wr_row_i : load_row_i;
    assign mem_rd_en   = (state == lu_pkg::ST_RUN) && lu_rd_valid_i && !flush_i;

    lu_row_ram #(
        .SIZE  (SIZE),
        .ROW_W (ROW_W)
    ) u_ram (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .rd_en     (mem_rd_en),
        .rd_addr   (lu_rd_addr_i),
        .rd_data   (lu_row_o),
        .rd_addr_q (lu_row_addr_o),
        .rd_valid  (lu_row_valid_o),
        .wr_en     (mem_wr_en),
        .wr_addr   (mem_wr_addr),
        .wr_data   (mem_wr_data),
        .peek_addr (cnt),
        .peek_data (peek_data)
    );

    // IDLE is the reset state but still offers load_ready; gating with the
    // reset input keeps every output low while reset is held.
    assign load_ready_o  = load_ready && rst_ni;
    assign lu_wr_ready_o = wr_ready;
    assign lu_start_o    = start;
    assign dump_valid_o  = dump_valid;
    assign dump_row_o    = dump_valid ? peek_data : '0;
    assign dump_addr_o   = dump_valid ? cnt : '0;
    assign busy_o        = (state != lu_pkg::ST_IDLE);

endmodule

// File: tb/tb_lu_mat_buf.sv
// tb/tb_lu_mat_buf.sv - randomized self-checking bench for lu_mat_buf
module tb_lu_mat_buf;

    localparam int SIZE  = 32;
    localparam int WIDTH = 64;
    localparam int AW    = $clog2(SIZE);
    localparam int ROW_W = SIZE * 2 * WIDTH;
    localparam logic [63:0] ONE = 64'h3FF0000000000000;
    localparam logic [63:0] TWO = 64'h4000000000000000;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             flush_i = 1'b0;
    logic [ROW_W-1:0] load_row_i = '0;
    logic             load_valid_i = 1'b0;
    logic             load_ready_o;
    logic             lu_start_o;
    logic             lu_busy_i = 1'b0;
    logic [AW-1:0]    lu_rd_addr_i = '0;
    logic             lu_rd_valid_i = 1'b0;
    logic [ROW_W-1:0] lu_row_o;
    logic [AW-1:0]    lu_row_addr_o;
    logic             lu_row_valid_o;
    logic [ROW_W-1:0] lu_wr_row_i = '0;
    logic [AW-1:0]    lu_wr_addr_i = '0;
    logic             lu_wr_valid_i = 1'b0;
    logic             lu_wr_ready_o;
    logic [ROW_W-1:0] dump_row_o;
    logic [AW-1:0]    dump_addr_o;
    logic             dump_valid_o;
    logic             dump_ready_i = 1'b0;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ROW_W-1:0] model [SIZE];
    logic [ROW_W-1:0] stim  [SIZE];

    lu_mat_buf #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .load_row_i     (load_row_i),
        .load_valid_i   (load_valid_i),
        .load_ready_o   (load_ready_o),
        .lu_start_o     (lu_start_o),
        .lu_busy_i      (lu_busy_i),
        .lu_rd_addr_i   (lu_rd_addr_i),
        .lu_rd_valid_i  (lu_rd_valid_i),
        .lu_row_o       (lu_row_o),
        .lu_row_addr_o  (lu_row_addr_o),
        .lu_row_valid_o (lu_row_valid_o),
        .lu_wr_row_i    (lu_wr_row_i),
        .lu_wr_addr_i   (lu_wr_addr_i),
        .lu_wr_valid_i  (lu_wr_valid_i),
        .lu_wr_ready_o  (lu_wr_ready_o),
        .dump_row_o     (dump_row_o),
        .dump_addr_o    (dump_addr_o),
        .dump_valid_o   (dump_valid_o),
        .dump_ready_i   (dump_ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] fold(input logic [ROW_W-1:0] r);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < ROW_W / 64; k++) f ^= r[k*64 +: 64];
        return f;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] ident_row(input int i);
        logic [ROW_W-1:0] r;
        r = '0;
        r[i*2*WIDTH +: WIDTH] = ONE;
        return r;
    endfunction

    function automatic logic any_out();
        return load_ready_o | lu_start_o | (|lu_row_o) | (|lu_row_addr_o) | lu_row_valid_o |
               lu_wr_ready_o | (|dump_row_o) | (|dump_addr_o) | dump_valid_o | busy_o;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got any=%b want 0", any_out());
        end
        step(); step();
        n_checks++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL reset_held_outputs: got any=%b want 0", any_out());
        end
        rst_ni = 1'b1;
        step();
        n_checks++;
        if (load_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", load_ready_o, busy_o);
        end
    endtask

    // Continuous host stream of stim[]; valid is held one cycle past the last row.
    task automatic test_load();
        int acc;
        acc = 0;
        for (int i = 0; i <= SIZE; i++) begin
            load_row_i   = stim[(i < SIZE) ? i : SIZE-1];
            load_valid_i = 1'b1;
            #1;
            if (i < SIZE) begin
                n_checks++;
                if (load_ready_o !== 1'b1 || lu_start_o !== 1'b0) begin
                    n_fail++; $display("FAIL load_ready row %0d: ready=%b start=%b want 1/0", i, load_ready_o, lu_start_o);
                end
            end else begin
                n_checks++;
                if (lu_start_o !== 1'b1 || load_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_fail++; $display("FAIL start_pulse: start=%b ready=%b busy=%b want 1/0/1", lu_start_o, load_ready_o, busy_o);
                end
            end
            if (load_ready_o === 1'b1 && acc < SIZE) begin
                model[acc] = stim[acc];
                acc++;
            end
            step();
        end
        load_valid_i = 1'b0;
        #1;
        n_checks++;
        if (acc != SIZE || lu_start_o !== 1'b0 || lu_wr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL load_accepts: accepts=%0d start=%b wr_ready=%b want %0d/0/1", acc, lu_start_o, lu_wr_ready_o, SIZE);
        end
    endtask

    task automatic test_read_basic();
        lu_rd_valid_i = 1'b1;
        lu_rd_addr_i  = AW'(5);
        step();
        lu_rd_valid_i = 1'b0;
        #1;
        n_checks++;
        if (lu_row_valid_o !== 1'b1 || lu_row_addr_o !== AW'(5)) begin
            n_fail++; $display("FAIL read5_handshake: valid=%b addr=%0d want 1/5", lu_row_valid_o, lu_row_addr_o);
        end
        n_checks++;
        if (lu_row_o[5*2*WIDTH +: WIDTH] !== ONE || lu_row_o !== model[5]) begin
            n_fail++; $display("FAIL read5_data: elem5.re=%h fold=%h want %h fold=%h",
                               lu_row_o[5*2*WIDTH +: WIDTH], fold(lu_row_o), ONE, fold(model[5]));
        end
        step();
        n_checks++;
        if (lu_row_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL read_idle_valid: got %b want 0", lu_row_valid_o);
        end
    endtask

    task automatic test_random_rw(input int n);
        logic             exp_v;
        logic [AW-1:0]    exp_a;
        logic [ROW_W-1:0] exp_r;
        for (int c = 0; c < n; c++) begin
            logic             rv, wv;
            logic [AW-1:0]    ra, wa;
            logic [ROW_W-1:0] wr;
            rv = ($urandom_range(3) != 0);
            wv = ($urandom_range(1) != 0);
            ra = AW'($urandom_range(SIZE-1));
            wa = AW'($urandom_range(SIZE-1));
            wr = rand_row();
            lu_rd_valid_i = rv; lu_rd_addr_i = ra;
            lu_wr_valid_i = wv; lu_wr_addr_i = wa; lu_wr_row_i = wr;
            #1;
            n_checks++;
            if (lu_wr_ready_o !== 1'b1 || dump_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rw_state cyc %0d: wr_ready=%b dump_valid=%b want 1/0", c, lu_wr_ready_o, dump_valid_o);
            end
            exp_v = rv; exp_a = ra; exp_r = model[ra];
            if (wv) model[wa] = wr;
            step();
            n_checks++;
            if (lu_row_valid_o !== exp_v) begin
                n_fail++; $display("FAIL rw_valid cyc %0d: got %b want %b", c, lu_row_valid_o, exp_v);
            end else if (exp_v) begin
                n_checks++;
                if (lu_row_addr_o !== exp_a || lu_row_o !== exp_r) begin
                    n_fail++; $display("FAIL rw_data cyc %0d: addr=%0d fold=%h want addr=%0d fold=%h",
                                       c, lu_row_addr_o, fold(lu_row_o), exp_a, fold(exp_r));
                end
            end
        end
        lu_rd_valid_i = 1'b0;
        lu_wr_valid_i = 1'b0;
    endtask

    task automatic test_collision();
        logic [ROW_W-1:0] two_row, old;
        two_row = '0;
        for (int j = 0; j < SIZE; j++) two_row[j*2*WIDTH +: WIDTH] = TWO;
        old = model[3];
        lu_rd_valid_i = 1'b1; lu_rd_addr_i = AW'(3);
        lu_wr_valid_i = 1'b1; lu_wr_addr_i = AW'(3); lu_wr_row_i = two_row;
        model[3] = two_row;
        step();
        lu_wr_valid_i = 1'b0;
        #1;
        n_checks++;
        if (lu_row_valid_o !== 1'b1 || lu_row_addr_o !== AW'(3) || lu_row_o !== old) begin
            n_fail++; $display("FAIL collision_old: valid=%b addr=%0d fold=%h want 1/3 fold=%h",
                               lu_row_valid_o, lu_row_addr_o, fold(lu_row_o), fold(old));
        end
        step();
        lu_rd_valid_i = 1'b0;
        #1;
        n_checks++;
        if (lu_row_o !== two_row || lu_row_o[3*2*WIDTH +: WIDTH] !== TWO) begin
            n_fail++; $display("FAIL collision_new: elem3.re=%h fold=%h want %h fold=%h",
                               lu_row_o[3*2*WIDTH +: WIDTH], fold(lu_row_o), TWO, fold(two_row));
        end
        step();
    endtask

    task automatic test_busy_exit();
        logic [AW-1:0]    wa;
        logic [ROW_W-1:0] wr;
        for (int c = 0; c < 10; c++) begin
            lu_busy_i = 1'b1;
            #1;
            n_checks++;
            if (lu_wr_ready_o !== 1'b1 || dump_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL busy_run cyc %0d: wr_ready=%b dump_valid=%b busy=%b want 1/0/1",
                                   c, lu_wr_ready_o, dump_valid_o, busy_o);
            end
            step();
        end
        // Busy falls together with a write-back: exit must wait for it.
        wa = AW'($urandom_range(SIZE-1));
        wr = rand_row();
        lu_busy_i = 1'b0;
        lu_wr_valid_i = 1'b1; lu_wr_addr_i = wa; lu_wr_row_i = wr;
        model[wa] = wr;
        step();
        lu_wr_valid_i = 1'b0;
        #1;
        n_checks++;
        if (lu_wr_ready_o !== 1'b1 || dump_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL exit_blocked_by_write: wr_ready=%b dump_valid=%b want 1/0", lu_wr_ready_o, dump_valid_o);
        end
        step();
        n_checks++;
        if (dump_valid_o !== 1'b1 || lu_wr_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL enter_dump: dump_valid=%b wr_ready=%b want 1/0", dump_valid_o, lu_wr_ready_o);
        end
    endtask

    task automatic test_dump(input int stop_at);
        int idx, cyc;
        idx = 0;
        cyc = 0;
        while (idx < stop_at && cyc < 400) begin
            dump_ready_i = (cyc % 2 == 1);
            #1;
            n_checks++;
            if (dump_valid_o !== 1'b1 || dump_addr_o !== AW'(idx) || dump_row_o !== model[idx]) begin
                n_fail++; $display("FAIL dump_row %0d: valid=%b addr=%0d fold=%h want 1/%0d fold=%h",
                                   idx, dump_valid_o, dump_addr_o, fold(dump_row_o), idx, fold(model[idx]));
            end
            if (dump_valid_o === 1'b1 && dump_ready_i) idx++;
            step();
            cyc++;
        end
        dump_ready_i = 1'b0;
        n_checks++;
        if (idx != stop_at) begin
            n_fail++; $display("FAIL dump_timeout: delivered %0d rows want %0d", idx, stop_at);
        end
        if (stop_at == SIZE) begin
            #1;
            n_checks++;
            if (busy_o !== 1'b0 || load_ready_o !== 1'b1 || dump_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL dump_to_idle: busy=%b ready=%b dump_valid=%b want 0/1/0", busy_o, load_ready_o, dump_valid_o);
            end
        end
    endtask

    task automatic test_flush_load();
        for (int i = 0; i < 7; i++) begin
            load_row_i = rand_row();
            load_valid_i = 1'b1;
            #1;
            n_checks++;
            if (load_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL flush_preload row %0d: ready=%b want 1", i, load_ready_o);
            end
            step();
        end
        load_row_i = rand_row();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        load_valid_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || load_ready_o !== 1'b1 || lu_start_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b ready=%b start=%b want 0/1/0", busy_o, load_ready_o, lu_start_o);
        end
        step();
        n_checks++;
        if (lu_start_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_start: start=%b busy=%b want 0/0", lu_start_o, busy_o);
        end
        for (int i = 0; i < SIZE; i++) stim[i] = rand_row();
        test_load();
    endtask

    task automatic test_reset_in_dump();
        for (int i = 0; i < SIZE; i++) stim[i] = rand_row();
        test_load();
        test_busy_exit();
        test_dump(12);
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_dump: got any=%b want 0 (dump_valid=%b busy=%b)", any_out(), dump_valid_o, busy_o);
        end
        step(); step();
        rst_ni = 1'b1;
        step();
        n_checks++;
        if (busy_o !== 1'b0 || load_ready_o !== 1'b1 || dump_valid_o !== 1'b0 || lu_row_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: busy=%b ready=%b dump_valid=%b row_valid=%b want 0/1/0/0",
                               busy_o, load_ready_o, dump_valid_o, lu_row_valid_o);
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < SIZE; i++) stim[i] = ident_row(i);
        test_load();
        test_read_basic();
        test_random_rw(40);
        test_collision();
        test_busy_exit();
        test_dump(SIZE);
        test_flush_load();
        test_random_rw(30);
        test_busy_exit();
        test_dump(SIZE);
        test_reset_in_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lu_mat_buf.md
Name: lu_mat_buf

Overview:
Row-organised complex-matrix buffer upstream of the lu engine.
- Accepts a SIZE x SIZE complex matrix streamed row by row from a host.
- Pulses start to lu, then serves its row read requests with fixed 1-cycle latency and absorbs its row write-backs.
- When lu finishes, streams the updated matrix back to the host.

Parameters:
SIZE, 32, matrix dimension (rows = columns); power of two, >= 2
WIDTH, 64, bits per real/imag part (IEEE double)
AW, $clog2(SIZE), row address width (derived, not overridable)
ROW_W, SIZE*2*WIDTH, row width; element j = bits [j*2W +: 2W], real in the low W bits, imag in the high W bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous abort to IDLE
load_row_i  in  ROW_W  host input row
load_valid_i  in  1  host row valid
load_ready_o  out  1  buffer accepts host row
lu_start_o  out  1  one-cycle start pulse to lu
lu_busy_i  in  1  lu busy
lu_rd_addr_i  in  AW  lu row read address
lu_rd_valid_i  in  1  lu read request
lu_row_o  out  ROW_W  row data to lu
lu_row_addr_o  out  AW  address echo of returned row
lu_row_valid_o  out  1  returned row valid
lu_wr_row_i  in  ROW_W  write-back row from lu
lu_wr_addr_i  in  AW  write-back address
lu_wr_valid_i  in  1  write-back valid
lu_wr_ready_o  out  1  write-back accepted
dump_row_o  out  ROW_W  result row to host
dump_addr_o  out  AW  index of dump row
dump_valid_o  out  1  dump row valid
dump_ready_i  in  1  host accepts dump row
busy_o  out  1  high in any state except IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_ni.
- Reset values: all outputs 0, state IDLE, row counter 0, storage contents undefined.
- Storage: SIZE x ROW_W register array.
- Handshakes: a transfer occurs when valid && ready. Data is held stable while valid && !ready.

FSM: IDLE -> LOAD -> START -> RUN -> DUMP -> IDLE.
- IDLE: load_ready_o = 1. The first accepted load_valid_i writes row 0, sets cnt = 1 and moves to LOAD.
- LOAD:
  - load_ready_o = 1.
  - Each accepted row is written to mem[cnt] and cnt increments.
  - Accepting row SIZE-1 moves to START and clears cnt. No wrap beyond SIZE-1.
- START: lu_start_o = 1 for exactly one cycle, then RUN. lu_busy_i is not checked on this cycle.
- RUN:
  - Read: a request on cycle t produces lu_row_o = mem[lu_rd_addr_i], lu_row_addr_o = address, lu_row_valid_o = 1 on cycle t+1. Back-to-back reads run 1 per cycle.
  - Write: lu_wr_ready_o = 1 in RUN only. An accepted write updates mem on the next edge.
  - Same-address read and write in one cycle: the read returns the OLD data (read-before-write).
  - Exit to DUMP when lu_busy_i is low, it was high on some earlier RUN cycle (seen_busy flag), and no write is in the current cycle.
- DUMP:
  - Streams rows 0..SIZE-1 in order, with dump_addr_o = index.
  - dump_valid_o stays high until the row is accepted.
  - Accepting row SIZE-1 returns to IDLE and clears cnt.
- Outside their states, load_ready_o, lu_wr_ready_o, dump_valid_o and lu_row_valid_o are all 0.
  - Read requests outside RUN are ignored.
  - lu_row_valid_o still completes a read issued in the last RUN cycle.
- flush_i (any state):
  - Next cycle is IDLE with cnt = 0 and all valids, ready and lu_start_o deasserted.
  - Storage is not cleared.
  - flush_i has priority over any simultaneous handshake, and that handshake is not performed.
- Reset mid-operation: immediate return to reset values. The partially loaded matrix is discarded logically.

Decomposition:
Package lu_pkg:
- localparams WIDTH, SIZE.
- typedef cplx_t as a packed struct {im, re} of WIDTH bits each.
- typedef row_t as a packed array [SIZE] of cplx_t.
- state enum lu_buf_state_e.

Sub-module lu_row_ram:
- SIZE x ROW_W storage with one synchronous read port and one write port.
- Registered read-before-write output.
- Read address echo and valid pipeline.

Test Plan:
- Load identity matrix (re = 1.0, im = 0 on the diagonal) with a continuous host stream -> exactly SIZE accepts, lu_start_o high for 1 cycle the cycle after the row-31 accept, busy_o = 1.
- RUN, read addr 5 at cycle t -> at t+1 lu_row_addr_o = 5, lu_row_valid_o = 1, element 5 real = 64'h3FF0000000000000.
- RUN, same-cycle write addr 3 (all 2.0) and read addr 3 -> returned row is the old data; a read at the next cycle returns 64'h4000000000000000.
- lu_busy_i 1 for 10 cycles then 0 -> DUMP; dump_ready_i toggled every other cycle -> rows 0..31 delivered in order, row 3 holds the written data, then IDLE.
- flush_i asserted during LOAD after 7 rows -> next cycle IDLE, load_ready_o = 1, no lu_start_o; a new 32-row load succeeds.
- rst_ni low in DUMP at row 12 -> all outputs 0 immediately, state IDLE after release.
